// File: rtl/bit_tx_shaper.sv
// NRZ bit serializer: each accepted bit becomes SPS samples of +/-AMP, one sample every DIV clks.
// Define RAMP_SHAPING_EN to ramp level changes over the first four samples of a bit.
module bit_tx_shaper #(
  parameter int DIV = 4,
  parameter int SPS = 8,
  parameter int AMP = 31
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic              bit_ready,
  output logic signed [5:0] dataout,
  output logic              sample_valid,
  output logic              Bit_Sync,
  output logic              underrun
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW = $clog2(SPS);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SPS - 1);
  localparam logic signed [5:0] LVL_POS = 6'(AMP);
  localparam logic signed [5:0] LVL_NEG = 6'(-AMP);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  logic [1:0]        r_rst_sync;
  state_t            r_state, w_state_nxt;
  logic [DW-1:0]     r_div, w_div_nxt;
  logic [CW-1:0]     r_cnt, w_cnt_nxt;
  logic signed [5:0] r_level, w_level_nxt, w_sample;
  logic              w_strobe, w_boundary, w_accept;
  logic              w_emit, w_sync_nxt, w_under_nxt;

  // Release of rst reaches the accept logic only after two clk edges
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_rst_sync <= 2'b00;
    else      r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_strobe   = (r_div == DIV_LAST);
  assign w_boundary = w_strobe && (r_cnt == CNT_LAST);
  assign bit_ready  = (r_state == S_IDLE) || ((r_state == S_RUN) && w_boundary);
  assign w_accept   = bit_valid && bit_ready && r_rst_sync[1];

  // Next-state, divider/sample counter and output-event decode
  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = r_div;
    w_cnt_nxt   = r_cnt;
    w_level_nxt = r_level;
    w_emit      = 1'b0;
    w_sync_nxt  = 1'b0;
    w_under_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_div_nxt = {DW{1'b0}};
        w_cnt_nxt = {CW{1'b0}};
        if (w_accept) begin
          w_state_nxt = S_RUN;
          w_level_nxt = bit_in ? LVL_POS : LVL_NEG;
          w_emit      = 1'b1;
          w_sync_nxt  = 1'b1;
        end else begin
          w_level_nxt = 6'sd0;
        end
      end
      S_RUN: begin
        if (!w_strobe) begin
          w_div_nxt = r_div + DW'(1);
        end else begin
          w_div_nxt = {DW{1'b0}};
          if (r_cnt != CNT_LAST) begin
            w_cnt_nxt = r_cnt + CW'(1);
            w_emit    = 1'b1;
          end else if (w_accept) begin
            w_cnt_nxt   = {CW{1'b0}};
            w_level_nxt = bit_in ? LVL_POS : LVL_NEG;
            w_emit      = 1'b1;
            w_sync_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = {CW{1'b0}};
            w_level_nxt = 6'sd0;
            w_under_nxt = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_div_nxt   = {DW{1'b0}};
        w_cnt_nxt   = {CW{1'b0}};
        w_level_nxt = 6'sd0;
      end
    endcase
  end

`ifdef RAMP_SHAPING_EN
  logic signed [5:0] r_prev, w_prev_nxt;

  function automatic logic signed [5:0] ramp(input logic signed [5:0] p,
                                             input logic signed [5:0] n,
                                             input logic [CW-1:0]     k);
    logic signed [11:0] diff;
    logic signed [11:0] mult;
    logic signed [11:0] step;
    diff = {{6{n[5]}}, n} - {{6{p[5]}}, p};
    mult = {10'd0, k[1:0]} + 12'sd1;
    step = (diff * mult) >>> 2;
    if ((k > CW'(3)) || (n == p)) return n;
    else                          return 6'({{6{p[5]}}, p} + step);
  endfunction

  // The level before the current bit; zero whenever a bit starts from idle
  always_comb begin
    w_prev_nxt = r_prev;
    if (w_accept && (r_state == S_RUN)) w_prev_nxt = r_level;
    else if (r_state == S_IDLE)         w_prev_nxt = 6'sd0;
    else                                w_prev_nxt = r_prev;
  end

  // Previous-level register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_prev <= 6'sd0;
    else      r_prev <= w_prev_nxt;
  end

  assign w_sample = ramp(w_prev_nxt, w_level_nxt, w_cnt_nxt);
`else
  assign w_sample = w_level_nxt;
`endif

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_div        <= {DW{1'b0}};
      r_cnt        <= {CW{1'b0}};
      r_level      <= 6'sd0;
      dataout      <= 6'sd0;
      sample_valid <= 1'b0;
      Bit_Sync     <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_div        <= w_div_nxt;
      r_cnt        <= w_cnt_nxt;
      r_level      <= w_level_nxt;
      sample_valid <= w_emit;
      Bit_Sync     <= w_sync_nxt;
      underrun     <= w_under_nxt;
      if (w_emit)                     dataout <= w_sample;
      else if (w_state_nxt == S_IDLE) dataout <= 6'sd0;
      else                            dataout <= dataout;
    end
  end

endmodule

// File: tb/tb_bit_tx_shaper.sv
// Directed bench for bit_tx_shaper: default instance plus a DIV=1/SPS=4/AMP=1 instance.
module tb_bit_tx_shaper;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic bit_in = 1'b0, bit_valid = 1'b0;
  logic bit_ready, sample_valid, Bit_Sync, underrun;
  logic signed [5:0] dataout;
  logic bit_in2 = 1'b0, bit_valid2 = 1'b0;
  logic bit_ready2, sample_valid2, Bit_Sync2, underrun2;
  logic signed [5:0] dataout2;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int acc_cyc[16];

  int s1_val[$];
  int s1_cyc[$];
  bit s1_sync[$];
  int u1_cnt = 0;
  int u1_cyc = 0;
  int s2_val[$];
  int s2_sync_cyc[$];
  int u2_cnt = 0;

`ifdef RAMP_SHAPING_EN
  int exp01[16] = '{-8, -16, -24, -31, -31, -31, -31, -31, -16, 0, 15, 31, 31, 31, 31, 31};
  int exp10[16] = '{7, 15, 23, 31, 31, 31, 31, 31, 15, 0, -16, -31, -31, -31, -31, -31};
  int first_neg = -8;
`else
  int exp01[16] = '{-31, -31, -31, -31, -31, -31, -31, -31, 31, 31, 31, 31, 31, 31, 31, 31};
  int exp10[16] = '{31, 31, 31, 31, 31, 31, 31, 31, -31, -31, -31, -31, -31, -31, -31, -31};
  int first_neg = -31;
`endif

  bit_tx_shaper u_dut (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready),
    .dataout(dataout), .sample_valid(sample_valid), .Bit_Sync(Bit_Sync), .underrun(underrun)
  );

  bit_tx_shaper #(.DIV(1), .SPS(4), .AMP(1)) u_dut2 (
    .clk(clk), .rst(rst), .bit_in(bit_in2), .bit_valid(bit_valid2), .bit_ready(bit_ready2),
    .dataout(dataout2), .sample_valid(sample_valid2), .Bit_Sync(Bit_Sync2), .underrun(underrun2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (sample_valid) begin
      s1_val.push_back(int'(dataout));
      s1_cyc.push_back(cyc);
      s1_sync.push_back(Bit_Sync);
    end
    if (underrun) begin
      u1_cnt <= u1_cnt + 1;
      u1_cyc <= cyc;
    end
    if (sample_valid2) s2_val.push_back(int'(dataout2));
    if (Bit_Sync2) s2_sync_cyc.push_back(cyc);
    if (underrun2) u2_cnt <= u2_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_q();
    s1_val.delete();
    s1_cyc.delete();
    s1_sync.delete();
  endtask

  task automatic send_bits(input logic [15:0] bits, input int n);
    int i;
    int guard;
    i = 0;
    guard = 0;
    while (i < n && guard < 1000) begin
      bit_valid = 1'b1;
      bit_in = bits[i];
      if (bit_ready) begin
        acc_cyc[i] = cyc;
        i++;
      end
      @(negedge clk);
      guard++;
    end
    bit_valid = 1'b0;
    tests++;
    if (i != n) begin
      fails++;
      $display("FAIL send_bits: accepted %0d bits, required %0d", i, n);
    end
  endtask

  task automatic test_reset();
    bit_valid = 1'b1;
    bit_in = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    tests++; if (dataout !== 6'sd0) begin fails++; $display("FAIL reset_dataout: got %0d want 0", dataout); end
    tests++; if (sample_valid !== 1'b0) begin fails++; $display("FAIL reset_sv: got %b want 0", sample_valid); end
    tests++; if (Bit_Sync !== 1'b0) begin fails++; $display("FAIL reset_sync: got %b want 0", Bit_Sync); end
    tests++; if (underrun !== 1'b0) begin fails++; $display("FAIL reset_underrun: got %b want 0", underrun); end
    tests++; if (bit_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", bit_ready); end
    tests++; if (s1_val.size() != 0) begin fails++; $display("FAIL reset_no_accept: got %0d samples want 0", s1_val.size()); end
    bit_valid = 1'b0;
    rst = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_nrz_stream();
    int u0;
    int n;
    logic [15:0] pat;
    pat = 16'b101;
    u0 = u1_cnt;
    clear_q();
    send_bits(pat, 3);
    repeat (40) @(negedge clk);
    #1;
    n = s1_val.size();
    tests++; if (n != 24) begin fails++; $display("FAIL nrz_count: got %0d samples want 24", n); end
    for (int i = 0; i < n && i < 24; i++) begin
      tests++;
      if (s1_val[i] != (pat[i / 8] ? 31 : -31)) begin
        fails++; $display("FAIL nrz_value[%0d]: got %0d want %0d", i, s1_val[i], pat[i / 8] ? 31 : -31);
      end
      tests++;
      if (s1_sync[i] != ((i % 8) == 0)) begin
        fails++; $display("FAIL nrz_sync[%0d]: got %b want %b", i, s1_sync[i], (i % 8) == 0);
      end
      if (i > 0) begin
        tests++;
        if (s1_cyc[i] - s1_cyc[i - 1] != 4) begin
          fails++; $display("FAIL nrz_spacing[%0d]: got %0d want 4", i, s1_cyc[i] - s1_cyc[i - 1]);
        end
      end
    end
    if (n > 0) begin
      tests++; if (s1_cyc[0] != acc_cyc[0] + 1) begin fails++; $display("FAIL nrz_latency: got %0d want %0d", s1_cyc[0], acc_cyc[0] + 1); end
      tests++; if (u1_cyc != s1_cyc[0] + 96) begin fails++; $display("FAIL nrz_underrun_time: got %0d want %0d", u1_cyc, s1_cyc[0] + 96); end
    end
    tests++; if (acc_cyc[1] - acc_cyc[0] != 32) begin fails++; $display("FAIL nrz_bit_period0: got %0d want 32", acc_cyc[1] - acc_cyc[0]); end
    tests++; if (acc_cyc[2] - acc_cyc[1] != 32) begin fails++; $display("FAIL nrz_bit_period1: got %0d want 32", acc_cyc[2] - acc_cyc[1]); end
    tests++; if (u1_cnt - u0 != 1) begin fails++; $display("FAIL nrz_underrun_count: got %0d want 1", u1_cnt - u0); end
    tests++; if (dataout !== 6'sd0) begin fails++; $display("FAIL nrz_idle_data: got %0d want 0", dataout); end
    tests++; if (bit_ready !== 1'b1) begin fails++; $display("FAIL nrz_idle_ready: got %b want 1", bit_ready); end
  endtask

  task automatic test_ramp_rise();
    clear_q();
    send_bits(16'b10, 2);
    repeat (70) @(negedge clk);
    #1;
    tests++; if (s1_val.size() != 16) begin fails++; $display("FAIL rise_count: got %0d want 16", s1_val.size()); end
    for (int i = 0; i < s1_val.size() && i < 16; i++) begin
      tests++;
      if (s1_val[i] != exp01[i]) begin fails++; $display("FAIL rise_value[%0d]: got %0d want %0d", i, s1_val[i], exp01[i]); end
    end
  endtask

  task automatic test_ramp_fall();
    clear_q();
    send_bits(16'b01, 2);
    repeat (70) @(negedge clk);
    #1;
    tests++; if (s1_val.size() != 16) begin fails++; $display("FAIL fall_count: got %0d want 16", s1_val.size()); end
    for (int i = 0; i < s1_val.size() && i < 16; i++) begin
      tests++;
      if (s1_val[i] != exp10[i]) begin fails++; $display("FAIL fall_value[%0d]: got %0d want %0d", i, s1_val[i], exp10[i]); end
    end
  endtask

  task automatic test_underrun_restart();
    int u0;
    u0 = u1_cnt;
    clear_q();
    send_bits(16'b1, 1);
    repeat (40) @(negedge clk);
    #1;
    tests++; if (u1_cnt - u0 != 1) begin fails++; $display("FAIL gap_underrun_count: got %0d want 1", u1_cnt - u0); end
    tests++; if (bit_ready !== 1'b1) begin fails++; $display("FAIL gap_idle_ready: got %b want 1", bit_ready); end
    tests++; if (dataout !== 6'sd0) begin fails++; $display("FAIL gap_idle_data: got %0d want 0", dataout); end
    clear_q();
    send_bits(16'b0, 1);
    repeat (2) @(negedge clk);
    #1;
    tests++; if (s1_val.size() < 1) begin fails++; $display("FAIL restart_count: got %0d want >=1", s1_val.size()); end
    if (s1_val.size() > 0) begin
      tests++; if (s1_sync[0] != 1'b1) begin fails++; $display("FAIL restart_sync: got %b want 1", s1_sync[0]); end
      tests++; if (s1_cyc[0] != acc_cyc[0] + 1) begin fails++; $display("FAIL restart_latency: got %0d want %0d", s1_cyc[0], acc_cyc[0] + 1); end
      tests++; if (s1_val[0] != first_neg) begin fails++; $display("FAIL restart_value: got %0d want %0d", s1_val[0], first_neg); end
    end
    repeat (40) @(negedge clk);
  endtask

  task automatic test_midbit_reset();
    int u0;
    u0 = u1_cnt;
    clear_q();
    send_bits(16'b1, 1);
    for (int g = 0; g < 100 && s1_val.size() < 6; g++) begin
      @(negedge clk);
      #1;
    end
    tests++; if (s1_val.size() < 6) begin fails++; $display("FAIL midrst_reach: got %0d samples want 6", s1_val.size()); end
    #1;
    rst = 1'b0;
    #1;
    tests++; if (dataout !== 6'sd0) begin fails++; $display("FAIL midrst_data: got %0d want 0", dataout); end
    tests++; if (sample_valid !== 1'b0) begin fails++; $display("FAIL midrst_sv: got %b want 0", sample_valid); end
    tests++; if (bit_ready !== 1'b1) begin fails++; $display("FAIL midrst_ready: got %b want 1", bit_ready); end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    #1;
    tests++; if (u1_cnt != u0) begin fails++; $display("FAIL midrst_underrun: got %0d pulses want 0", u1_cnt - u0); end
    clear_q();
    send_bits(16'b0, 1);
    repeat (2) @(negedge clk);
    #1;
    tests++; if (s1_val.size() < 1) begin fails++; $display("FAIL midrst_restart_count: got %0d want >=1", s1_val.size()); end
    if (s1_val.size() > 0) begin
      tests++; if (s1_sync[0] != 1'b1) begin fails++; $display("FAIL midrst_restart_sync: got %b want 1", s1_sync[0]); end
      tests++; if (s1_val[0] != first_neg) begin fails++; $display("FAIL midrst_restart_value: got %0d want %0d", s1_val[0], first_neg); end
      tests++; if (s1_cyc[0] != acc_cyc[0] + 1) begin fails++; $display("FAIL midrst_restart_latency: got %0d want %0d", s1_cyc[0], acc_cyc[0] + 1); end
    end
    repeat (40) @(negedge clk);
  endtask

  task automatic test_random_small();
    int acc2[40];
    bit b2[40];
    int i;
    int guard;
    int u0;
    int exp_under;
    int idx;
    int lvl;
    int e;
    bit contig;
`ifdef RAMP_SHAPING_EN
    int p;
`endif
    for (int j = 0; j < 40; j++) b2[j] = ($urandom_range(0, 1) == 1);
    u0 = u2_cnt;
    s2_val.delete();
    s2_sync_cyc.delete();
    i = 0;
    guard = 0;
    while (i < 40 && guard < 4000) begin
      bit_valid2 = 1'b1;
      bit_in2 = b2[i];
      if (bit_ready2) begin
        acc2[i] = cyc;
        i++;
        @(negedge clk);
        if ($urandom_range(0, 2) == 0) begin
          bit_valid2 = 1'b0;
          repeat ($urandom_range(1, 6)) @(negedge clk);
        end
      end else begin
        @(negedge clk);
      end
      guard++;
    end
    bit_valid2 = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    tests++; if (i != 40) begin fails++; $display("FAIL rnd_accepts: got %0d want 40", i); end
    tests++; if (s2_val.size() != 4 * i) begin fails++; $display("FAIL rnd_sample_count: got %0d want %0d", s2_val.size(), 4 * i); end
    tests++; if (s2_sync_cyc.size() != i) begin fails++; $display("FAIL rnd_sync_count: got %0d want %0d", s2_sync_cyc.size(), i); end
    exp_under = 1;
    idx = 0;
    for (int b = 0; b < i; b++) begin
      lvl = b2[b] ? 1 : -1;
      contig = (b > 0) && (acc2[b] - acc2[b - 1] == 4);
      if (b > 0 && !contig) exp_under++;
`ifdef RAMP_SHAPING_EN
      p = contig ? (b2[b - 1] ? 1 : -1) : 0;
`endif
      if (b < s2_sync_cyc.size()) begin
        tests++;
        if (s2_sync_cyc[b] != acc2[b] + 1) begin
          fails++; $display("FAIL rnd_sync_time[%0d]: got %0d want %0d", b, s2_sync_cyc[b], acc2[b] + 1);
        end
      end
      for (int k = 0; k < 4; k++) begin
`ifdef RAMP_SHAPING_EN
        e = (k > 3 || p == lvl) ? lvl : p + (((lvl - p) * (k + 1)) >>> 2);
`else
        e = lvl;
`endif
        if (idx < s2_val.size()) begin
          tests++;
          if (s2_val[idx] != e) begin
            fails++; $display("FAIL rnd_value[%0d]: got %0d want %0d", idx, s2_val[idx], e);
          end
        end
        idx++;
      end
    end
    tests++; if (u2_cnt - u0 != exp_under) begin fails++; $display("FAIL rnd_underruns: got %0d want %0d", u2_cnt - u0, exp_under); end
  endtask

  initial begin
    test_reset();
    test_nrz_stream();
    test_ramp_rise();
    test_ramp_fall();
    test_underrun_restart();
    test_midbit_reset();
    test_random_small();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bit_tx_shaper.md
BIT_TX_SHAPER -- requirements
Module: bit_tx_shaper

Interface
REQ-001 SHALL have parameter DIV, default 4: clk cycles per output sample (4 gives 8 MS/s at 32 MHz).
REQ-002 SHALL have parameter SPS, default 8: samples per bit, a power of two ≥4.
REQ-003 SHALL have parameter AMP, default 31: NRZ amplitude, range 1..31.
REQ-004 SHALL have port clk, input, 1: single system clock, 32 MHz.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous assert, active-low.
REQ-006 SHALL have port bit_in, input, 1: bit to transmit, where 1 maps to +AMP and 0 maps to -AMP.
REQ-007 SHALL have port bit_valid, input, 1: bit_in is valid.
REQ-008 SHALL have port bit_ready, output, 1: bit is accepted on bit_valid&&bit_ready.
REQ-009 SHALL have port dataout, output, signed 6: shaped baseband sample.
REQ-010 SHALL have port sample_valid, output, 1: one-clk pulse marking each new dataout value.
REQ-011 SHALL have port Bit_Sync, output, 1: one-clk pulse coincident with sample_valid on sample 0 of each bit.
REQ-012 SHALL have port underrun, output, 1: one-clk pulse when a bit boundary finds no valid bit.

Function
REQ-013 SHALL implement FSM states IDLE and RUN.
REQ-014 IDLE SHALL: bit_ready=1; dataout=0; no sample_valid; the divider is held at 0.
REQ-015 Accept in IDLE at cycle t SHALL: go to RUN; sample_cnt=0; emit sample 0 with sample_valid=1 and Bit_Sync=1 at t+1.
REQ-016 In RUN, the strobe SHALL fire every DIV clks, and each strobe SHALL advance sample_cnt modulo SPS and update dataout with sample_valid=1.
REQ-017 In RUN, bit_ready SHALL be 1 only in the clk where the next strobe completes sample SPS-1; it SHALL be combinational from the divider and sample_cnt.
REQ-018 A bit accepted in that clk SHALL become the current bit, with its sample 0 on the next strobe, giving gap-free back-to-back bits.
REQ-019 If bit_valid=0 in that clk, the block SHALL: pulse underrun; go to IDLE; drive dataout=0 on the following clk.
REQ-020 bit_valid asserted while bit_ready=0 SHALL be ignored; the source holds the bit, as in standard valid/ready.
REQ-021 Each bit SHALL occupy exactly SPS*DIV clks, i.e. 32 clks at defaults, 1 Mb/s.
REQ-022 The previous level prev SHALL be 0 after IDLE, and ±AMP otherwise.
REQ-023 All arithmetic SHALL be signed, with ≥9-bit intermediates; dataout SHALL never leave [-AMP, +AMP].

Reset
REQ-024 rst=0 SHALL immediately force: FSM=IDLE; dataout=0; sample_valid=0; Bit_Sync=0; underrun=0; divider, sample_cnt and prev cleared.
REQ-025 bit_ready SHALL read 1 during reset (IDLE), but no accept is registered until rst=1.
REQ-026 Reset mid-bit SHALL discard the current bit with no underrun pulse.
REQ-027 Deassertion of rst SHALL be synchronized internally to clk with a 2-flop synchronizer.

Configuration
REQ-028 Macro RAMP_SHAPING_EN SHALL select transition shaping.
REQ-029 When RAMP_SHAPING_EN is defined, for samples k=0..3 of a bit whose level differs from prev, the block SHALL output prev + (((new-prev)*(k+1)) >>> 2), an arithmetic floor shift, and output the new level thereafter.
REQ-030 When RAMP_SHAPING_EN is undefined, the block SHALL output ideal NRZ steps at sample 0 with no ramp logic.

Verification
REQ-031 SHALL verify: reset, then bits 1,0,1 held valid continuously, no macro → dataout +31×8, -31×8, +31×8 samples; sample_valid every 4 clks; Bit_Sync every 32 clks; first sample_valid 1 clk after accept; then underrun pulse; dataout=0.
REQ-032 SHALL verify: RAMP_SHAPING_EN, bits 0 then 1 from IDLE → bit0 samples -8,-16,-24,-31,-31..; bit1 samples -16,0,15,31,31,31,31,31.
REQ-033 SHALL verify: RAMP_SHAPING_EN, bits 1 then 0 → bit0 samples 15,0,-16,-31, then -31×4.
REQ-034 SHALL verify: bit_valid dropped for one boundary then reasserted → underrun=1 once; IDLE; restart emits Bit_Sync 1 clk after accept.
REQ-035 SHALL verify: rst pulsed low at sample 5 of a bit → outputs 0 asynchronously; no underrun; first post-reset accepted bit starts at sample 0.
REQ-036 SHALL verify: DIV=1, SPS=4, AMP=1, random bits and valid gaps → scoreboard matches expected sample stream; no missed or duplicated bits.
